op_loader: RTL and testbench
============================

OP_LOADER -- requirements
Module: op_loader

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits.
REQ-002 Parameter HOLD, default 1, settle cycles between operand B acceptance and result capture; legal range 1..15.
REQ-003 One clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_data  in  WIDTH  operand stream, A first, then B.
REQ-007 in_valid  in  1  in_data valid.
REQ-008 in_ready  out  1  block accepts in_data this cycle.
REQ-009 op_a  out  WIDTH  registered operand A to the downstream combinational unit's first input.
REQ-010 op_b  out  WIDTH  registered operand B to the downstream combinational unit's second input.
REQ-011 op_res  in  WIDTH  combinational result returned by the downstream unit.
REQ-012 res_data  out  WIDTH  captured result.
REQ-013 res_valid  out  1  res_data valid.
REQ-014 res_ready  in  1  consumer accepts res_data.
REQ-015 busy  out  1  high in any state other than LOAD_A.
REQ-016 txn_cnt  out  8  completed-transaction count (see Configuration).

Function
REQ-017 FSM states SHALL be LOAD_A, LOAD_B, SETTLE, OUTPUT, one-hot or binary at implementer's choice.
REQ-018 LOAD_A: in_ready=1; on in_valid&in_ready, op_a<=in_data, go LOAD_B; else stay.
REQ-019 LOAD_B: in_ready=1; on in_valid&in_ready, op_b<=in_data, hold counter<=HOLD-1, go SETTLE; else stay.
REQ-020 SETTLE: in_ready=0; counter decrements each cycle; when counter==0, res_data<=op_res, res_valid<=1, go OUTPUT.
REQ-021 Latency: B accepted at edge N -> res_valid high after edge N+HOLD; HOLD=1 gives one full cycle of op_a/op_b stability before capture.
REQ-022 OUTPUT: in_ready=0, res_valid=1, res_data stable; on res_ready, res_valid<=0, go LOAD_A.
REQ-023 res_ready while res_valid=0 SHALL be ignored; in_valid while in_ready=0 SHALL be ignored (data not consumed).
REQ-024 op_a/op_b SHALL hold their last values after a transaction until overwritten by the next accepted beat.
REQ-025 in_ready SHALL be combinational decode of state only; no dependence on in_valid.
REQ-026 Back-to-back: in_valid held high with fresh data SHALL load A and B on consecutive edges.

Reset
REQ-027 rst_n low SHALL immediately force state=LOAD_A, op_a=0, op_b=0, res_data=0, res_valid=0, counter=0, txn_cnt=0.
REQ-028 in_ready SHALL be 0 while rst_n is low and 1 from the first cycle after deassertion.
REQ-029 Reset mid-transaction (any state) SHALL discard the partial/pending transaction without incrementing txn_cnt.

Configuration
REQ-030 Macro OP_LOADER_TXN_CNT_EN defined: txn_cnt increments by 1 on every OUTPUT handshake (res_valid&res_ready), wrapping 255->0.
REQ-031 Macro undefined: txn_cnt SHALL be tied to 8'h00 and no counter flops are synthesised; all other behaviour is identical.

Verification
Bench drives op_res = op_a & op_b as its downstream model, HOLD=1 unless stated.
REQ-032 Reset: rst_n low mid-SETTLE -> all outputs 0 at once, in_ready=1 one cycle after release, txn_cnt=0.
REQ-033 Basic: send 4'b1010 then 4'b1111, res_ready=1 -> op_a=1010, op_b=1111, res_valid one edge after B, res_data=4'b1010, txn_cnt=1.
REQ-034 Backpressure: send 0101/1111, hold res_ready=0 for 5 cycles while in_valid=1 with 0011 -> res_data=0101 stable, in_ready=0, 0011 not consumed until after handshake.
REQ-035 HOLD=4: send 1111/1111 -> res_valid rises exactly 4 edges after B accepted, res_data=1111.
REQ-036 Wrap: with OP_LOADER_TXN_CNT_EN, 256 transactions -> txn_cnt returns to 0; without macro txn_cnt stays 0 throughout.
REQ-037 Gaps: in_valid low 3 cycles between A and B -> FSM stays LOAD_B, busy=1, op_a unchanged, result correct.

Source files
------------

// File: rtl/op_loader.sv
// -----------------------------------------------------------------------------
// op_loader
//   Collects two operands (A then B) from a valid/ready stream, presents them
//   registered on op_a/op_b to an external combinational unit, waits HOLD
//   cycles for that unit to settle, captures op_res and offers it on a
//   valid/ready result port.
//
// Parameters
//   WIDTH  operand/result width
//   HOLD   settle cycles between B acceptance and result capture (1..15)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    operand stream, A first then B
//   in_ready            operand accepted this cycle (state decode only)
//   op_a/op_b           registered operands to the downstream unit
//   op_res              combinational result from the downstream unit
//   res_data/res_valid  captured result, held until res_ready
//   res_ready           consumer accepts the result
//   busy                high whenever a transaction is in flight
//   txn_cnt             completed-transaction count
//
// Configuration
//   OP_LOADER_TXN_CNT_EN  defined: txn_cnt counts result handshakes (mod 256)
//                         undefined: txn_cnt is constant zero, no counter flops
// -----------------------------------------------------------------------------
module op_loader #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_res,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [7:0]       txn_cnt
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        SETTLE = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    // Counter is loaded with HOLD-1 so that capture lands exactly HOLD edges
    // after B is accepted.
    localparam logic [3:0] HOLD_INIT = 4'(HOLD - 1);

    state_t     state;
    logic [3:0] hold_cnt;

    // in_ready is gated by rst_n so it reads 0 for the whole reset period,
    // even though state already sits in LOAD_A.
    assign in_ready = rst_n && ((state == LOAD_A) || (state == LOAD_B));
    assign busy     = (state != LOAD_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            op_a      <= '0;
            op_b      <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (in_valid && in_ready) begin
                        op_a  <= in_data;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_valid && in_ready) begin
                        op_b     <= in_data;
                        hold_cnt <= HOLD_INIT;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (hold_cnt == 4'd0) begin
                        res_data  <= op_res;
                        res_valid <= 1'b1;
                        state     <= OUTPUT;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= LOAD_A;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

`ifdef OP_LOADER_TXN_CNT_EN
    logic [7:0] cnt_q;

    // res_valid is only high in OUTPUT, so this is exactly the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 8'h00;
        else if (res_valid && res_ready)
            cnt_q <= cnt_q + 8'h01;
    end

    assign txn_cnt = cnt_q;
`else
    assign txn_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_op_loader.sv
// -----------------------------------------------------------------------------
// tb_op_loader
//   Two instances: HOLD=1 (scoreboarded random traffic) and HOLD=4 (directed
//   latency and mid-SETTLE reset). Downstream unit modelled as op_a & op_b.
// -----------------------------------------------------------------------------
module tb_op_loader;

    localparam int W      = 4;
    localparam int HOLD_A = 1;
    localparam int HOLD_B = 4;
    localparam int N_RAND = 300;

    logic         clk = 1'b0;
    logic         rst_n;

    // HOLD=1 instance
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a, op_b, op_res, res_data;
    logic         res_valid, res_ready, busy;
    logic [7:0]   txn_cnt;

    // HOLD=4 instance
    logic [W-1:0] h4_in_data;
    logic         h4_in_valid;
    logic         h4_in_ready;
    logic [W-1:0] h4_op_a, h4_op_b, h4_op_res, h4_res_data;
    logic         h4_res_valid, h4_res_ready, h4_busy;
    logic [7:0]   h4_txn_cnt;

    assign op_res    = op_a & op_b;
    assign h4_op_res = h4_op_a & h4_op_b;

    always #5 clk = ~clk;

    op_loader #(.WIDTH(W), .HOLD(HOLD_A)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_res(op_res),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .txn_cnt(txn_cnt)
    );

    op_loader #(.WIDTH(W), .HOLD(HOLD_B)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_data(h4_in_data), .in_valid(h4_in_valid), .in_ready(h4_in_ready),
        .op_a(h4_op_a), .op_b(h4_op_b), .op_res(h4_op_res),
        .res_data(h4_res_data), .res_valid(h4_res_valid), .res_ready(h4_res_ready),
        .busy(h4_busy), .txn_cnt(h4_txn_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit run   = 0;
    int done  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           bcyc;
    } txn_t;

    txn_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference count of completed transactions as seen on txn_cnt.
    function automatic logic [31:0] exp_cnt(input int n);
`ifdef OP_LOADER_TXN_CNT_EN
        return 32'(n % 256);
`else
        return 32'(n - n);
`endif
    endfunction

    // ---------------- HOLD=1 driver ----------------
    task automatic send_beat(input logic [W-1:0] d, input bit is_b, input logic [W-1:0] a);
        txn_t t;
        bit   ok = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("in_ready_timeout", 0, 1);
        if (is_b && ok) begin
            t.a = a; t.b = d; t.res = a & d; t.bcyc = cyc + 1;
            sb.push_back(t);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int gap_ab, input int gap_after);
        send_beat(a, 1'b0, '0);
        if (gap_ab > 0) begin
            in_valid = 1'b0;
            for (int g = 0; g < gap_ab; g++) begin
                in_data = W'($urandom);
                @(negedge clk);
                check("gap_busy", busy, 1);
                check("gap_op_a", op_a, a);
                @(posedge clk); #1;
            end
        end
        send_beat(b, 1'b1, a);
        if (gap_after > 0) begin
            in_valid = 1'b0;
            repeat (gap_after) @(posedge clk);
            #1;
        end
    endtask

    // ---------------- HOLD=1 monitor ----------------
    bit prev_vld = 0;
    bit pend     = 0;

    always @(negedge clk) begin
        if (run) begin
            if (pend) begin
                done++;
                check("txn_cnt", txn_cnt, exp_cnt(done));
                check("vld_drop", res_valid, 0);
                pend = 0;
            end else if (res_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    if (!prev_vld) check("latency", cyc, sb[0].bcyc + HOLD_A);
                    check("res_data", res_data, sb[0].res);
                    check("op_a_hold", op_a, sb[0].a);
                    check("op_b_hold", op_b, sb[0].b);
                    check("in_ready_out", in_ready, 0);
                    if (res_ready) begin
                        void'(sb.pop_front());
                        pend = 1;
                    end
                end
            end
            prev_vld = res_valid;
        end
    end

    // Result consumer: random acceptance with occasional 5-cycle stalls.
    initial begin
        res_ready = 1'b0;
        wait (run);
        while (run) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 7) == 0) begin
                res_ready = 1'b0;
                repeat (4) @(posedge clk);
            end else begin
                res_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // ---------------- HOLD=4 driver ----------------
    task automatic h4_beat(input logic [W-1:0] d, output int acc);
        bit ok = 0;
        acc = -1;
        h4_in_data  = d;
        h4_in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (h4_in_ready) begin
                ok = 1;
                acc = cyc + 1;
                break;
            end
        end
        if (!ok) check("h4_in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        h4_in_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        bit seen;
        logic [W-1:0] ra, rb;

        rst_n        = 1'b0;
        in_data      = '0;
        in_valid     = 1'b0;
        h4_in_data   = '0;
        h4_in_valid  = 1'b0;
        h4_res_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_txn_cnt", txn_cnt, 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_h4_in_ready", h4_in_ready, 1);
        @(posedge clk); #1;

        // HOLD=4: 1111/1111, result exactly 4 edges after B
        h4_beat(4'b1111, acc);
        h4_beat(4'b1111, acc);
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (h4_res_valid) begin
                seen = 1;
                break;
            end
        end
        check("h4_seen", seen, 1);
        check("h4_latency", cyc, acc + HOLD_B);
        check("h4_res_data", h4_res_data, 4'b1111);
        check("h4_in_ready_out", h4_in_ready, 0);
        @(posedge clk); #1;
        h4_res_ready = 1'b1;
        @(negedge clk);
        check("h4_res_valid_held", h4_res_valid, 1);
        @(negedge clk);
        check("h4_vld_drop", h4_res_valid, 0);
        check("h4_txn_cnt", h4_txn_cnt, exp_cnt(1));

        // Reset in the middle of SETTLE
        @(posedge clk); #1;
        h4_beat(4'b0110, acc);
        h4_beat(4'b0011, acc);
        @(negedge clk);
        check("h4_settle_busy", h4_busy, 1);
        check("h4_settle_in_ready", h4_in_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_op_a", h4_op_a, 0);
        check("mid_rst_op_b", h4_op_b, 0);
        check("mid_rst_res_data", h4_res_data, 0);
        check("mid_rst_res_valid", h4_res_valid, 0);
        check("mid_rst_busy", h4_busy, 0);
        check("mid_rst_in_ready", h4_in_ready, 0);
        check("mid_rst_txn_cnt", h4_txn_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_in_ready", h4_in_ready, 1);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (h4_res_valid) break;
        end
        check("mid_rel_no_result", h4_res_valid, 0);
        check("mid_rel_txn_cnt", h4_txn_cnt, 0);
        @(posedge clk); #1;

        // Scoreboarded traffic on the HOLD=1 instance
        run = 1;
        send_txn(4'b1010, 4'b1111, 0, 0);
        send_txn(4'b0101, 4'b1111, 0, 0);
        send_txn(4'b1100, 4'b0110, 3, 2);
        for (int i = 0; i < N_RAND; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            send_txn(ra, rb,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        in_valid = 1'b0;

        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
        run = 0;
        check("final_done", done, N_RAND + 3);
        check("final_txn_cnt", txn_cnt, exp_cnt(done));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
